// File: rtl/sysref_generator_if.sv
// Control/status bundle for sysref_generator: the slave modport is the generator,
// the master modport is whoever programs and starts it.
interface sysref_generator_if #(
  parameter int HP_W    = 16,
  parameter int BURST_W = 8
);
  logic [HP_W-1:0]    half_period;
  logic               burst_mode;
  logic [BURST_W-1:0] burst_count;
  logic               start;
  logic               stop;
  logic               user_sysref_adc;
  logic               user_sysref_dac;
  logic               busy;
  logic               done;

  modport master (
    output half_period,
    output burst_mode,
    output burst_count,
    output start,
    output stop,
    input  user_sysref_adc,
    input  user_sysref_dac,
    input  busy,
    input  done
  );

  modport slave (
    input  half_period,
    input  burst_mode,
    input  burst_count,
    input  start,
    input  stop,
    output user_sysref_adc,
    output user_sysref_dac,
    output busy,
    output done
  );
endinterface

// File: rtl/sysref_generator.sv
// 50%-duty SYSREF pulse generator (continuous or burst) with clean stop handling.
// Optional DAC skew delay line is compiled in only when SYSREF_DAC_SKEW_EN is defined.
module sysref_generator #(
  parameter int HP_W    = 16,
  parameter int BURST_W = 8
) (
  input  logic                 master_clock,
  input  logic                 aresetn,
`ifdef SYSREF_DAC_SKEW_EN
  input  logic [1:0]           dac_skew,
`endif
  sysref_generator_if.slave    bus
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_HIGH  = 2'd1;
  localparam logic [1:0] S_LOW   = 2'd2;
  localparam logic [1:0] S_DRAIN = 2'd3;

  localparam logic [HP_W-1:0]    HP_ONE    = {{(HP_W-1){1'b0}}, 1'b1};
  localparam logic [BURST_W-1:0] BURST_ONE = {{(BURST_W-1){1'b0}}, 1'b1};

  logic [1:0]         r_state;
  logic [HP_W-1:0]    r_cnt;
  logic [BURST_W-1:0] r_pulse;
  logic [HP_W-1:0]    r_hp;
  logic               r_burst_mode;
  logic [BURST_W-1:0] r_burst_cnt;
  logic               r_armed;
  logic               r_adc;
  logic               r_dac;
  logic               r_busy;
  logic               r_done;

  logic [1:0]         w_state_next;
  logic [HP_W-1:0]    w_cnt_next;
  logic [BURST_W-1:0] w_pulse_next;
  logic               w_adc_next;
  logic               w_done_next;
  logic               w_load;
  logic               w_cnt_last;
  logic               w_burst_last;
  logic [BURST_W-1:0] w_burst_target;
  logic               w_dac_next;

  // A count of 0 wraps to all-ones here, which yields 2^BURST_W pulses.
  assign w_burst_target = r_burst_cnt - BURST_ONE;
  assign w_cnt_last     = (r_cnt == r_hp);
  assign w_burst_last   = r_burst_mode && (r_pulse == w_burst_target);

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_pulse_next = r_pulse;
    w_adc_next   = r_adc;
    w_done_next  = 1'b0;
    w_load       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_armed && bus.start && !bus.stop) begin
          w_load       = 1'b1;
          w_state_next = S_HIGH;
          w_cnt_next   = '0;
          w_pulse_next = '0;
          w_adc_next   = 1'b1;
        end
      end
      S_HIGH: begin
        if (w_cnt_last) begin
          w_cnt_next = '0;
          w_adc_next = 1'b0;
          if (bus.stop) begin
            w_state_next = S_IDLE;
            w_done_next  = 1'b1;
          end else begin
            w_state_next = S_LOW;
          end
        end else begin
          w_cnt_next = r_cnt + HP_ONE;
          if (bus.stop) begin
            w_state_next = S_DRAIN;
          end
        end
      end
      S_LOW: begin
        if (bus.stop) begin
          w_state_next = S_IDLE;
          w_cnt_next   = '0;
          w_done_next  = 1'b1;
        end else if (w_cnt_last) begin
          w_cnt_next = '0;
          if (w_burst_last) begin
            w_state_next = S_IDLE;
            w_done_next  = 1'b1;
          end else begin
            w_state_next = S_HIGH;
            w_adc_next   = 1'b1;
            w_pulse_next = r_pulse + BURST_ONE;
          end
        end else begin
          w_cnt_next = r_cnt + HP_ONE;
        end
      end
      S_DRAIN: begin
        // Finish the high phase already on the wire so no runt pulse escapes.
        if (w_cnt_last) begin
          w_state_next = S_IDLE;
          w_cnt_next   = '0;
          w_adc_next   = 1'b0;
          w_done_next  = 1'b1;
        end else begin
          w_cnt_next = r_cnt + HP_ONE;
        end
      end
      default: begin
        w_state_next = S_IDLE;
        w_cnt_next   = '0;
        w_adc_next   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge master_clock or negedge aresetn) begin
    if (!aresetn) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_pulse      <= '0;
      r_hp         <= HP_ONE;
      r_burst_mode <= 1'b0;
      r_burst_cnt  <= '0;
      r_armed      <= 1'b0;
      r_adc        <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      // First edge after reset release only arms; start is honoured from the second.
      r_armed <= 1'b1;
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_pulse <= w_pulse_next;
      r_adc   <= w_adc_next;
      r_busy  <= (w_state_next != S_IDLE);
      r_done  <= w_done_next;
      if (w_load) begin
        r_hp         <= (bus.half_period == '0) ? HP_ONE : bus.half_period;
        r_burst_mode <= bus.burst_mode;
        r_burst_cnt  <= bus.burst_count;
      end
    end
  end

`ifdef SYSREF_DAC_SKEW_EN
  logic       r_hist [0:1];
  logic       w_chain [0:2];

  assign w_chain[0] = r_adc;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_hist
      assign w_chain[gi+1] = r_hist[gi];
      always_ff @(posedge master_clock or negedge aresetn) begin
        if (!aresetn) begin
          r_hist[gi] <= 1'b0;
        end else begin
          r_hist[gi] <= w_chain[gi];
        end
      end
    end
  endgenerate

  // Selecting from the pre-register value keeps skew 0 cycle-aligned with adc.
  always_comb begin
    w_dac_next = w_adc_next;
    case (dac_skew)
      2'd0:    w_dac_next = w_adc_next;
      2'd1:    w_dac_next = w_chain[0];
      2'd2:    w_dac_next = w_chain[1];
      default: w_dac_next = w_chain[2];
    endcase
  end
`else
  assign w_dac_next = w_adc_next;
`endif

  always_ff @(posedge master_clock or negedge aresetn) begin
    if (!aresetn) begin
      r_dac <= 1'b0;
    end else begin
      r_dac <= w_dac_next;
    end
  end

  assign bus.user_sysref_adc = r_adc;
  assign bus.user_sysref_dac = r_dac;
  assign bus.busy            = r_busy;
  assign bus.done            = r_done;

endmodule

// File: tb/tb_sysref_generator.sv
// Bench for sysref_generator: directed scenarios plus random traffic, every cycle
// compared against a waveform model computed from pulse index arithmetic.
module tb_sysref_generator;

  localparam int HP_W    = 16;
  localparam int BURST_W = 8;

  logic master_clock;
  logic aresetn;
`ifdef SYSREF_DAC_SKEW_EN
  logic [1:0] dac_skew;
`endif

  sysref_generator_if #(.HP_W(HP_W), .BURST_W(BURST_W)) bus ();

  sysref_generator #(.HP_W(HP_W), .BURST_W(BURST_W)) dut (
    .master_clock (master_clock),
    .aresetn      (aresetn),
`ifdef SYSREF_DAC_SKEW_EN
    .dac_skew     (dac_skew),
`endif
    .bus          (bus)
  );

  initial master_clock = 1'b0;
  always #5 master_clock = ~master_clock;

  int checks = 0;
  int errors = 0;

  // Reference model: a run is described by its start, half length, period and end index.
  bit m_active;
  bit m_armed;
  int m_k;
  int m_h1;
  int m_p;
  int m_end;
  bit exp_adc, exp_dac, exp_busy, exp_done;
  bit prev_adc;
  bit hist [0:2];

  task automatic check_val(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_active = 0;
    m_armed  = 0;
    m_k      = 0;
    m_end    = -1;
    exp_adc  = 0;
    exp_dac  = 0;
    exp_busy = 0;
    exp_done = 0;
    prev_adc = 0;
    for (int i = 0; i < 3; i++) hist[i] = 0;
  endtask

  task automatic model_step();
    int blk, e, n;
    exp_done = 0;
    if (m_active) begin
      if (bus.stop) begin
        blk = (m_k / m_p) * m_p;
        if ((m_k % m_p) < m_h1) e = blk + m_h1;
        else                    e = m_k + 1;
        if (m_end < 0 || e < m_end) m_end = e;
      end
      m_k++;
      if (m_k == m_end) begin
        m_active = 0;
        exp_done = 1;
        $display("run end  : k=%0d", m_k);
      end
    end else if (m_armed && bus.start && !bus.stop) begin
      m_active = 1;
      m_k      = 0;
      m_h1     = ((bus.half_period == 0) ? 1 : int'(bus.half_period)) + 1;
      m_p      = 2 * m_h1;
      n        = (bus.burst_count == 0) ? (1 << BURST_W) : int'(bus.burst_count);
      m_end    = bus.burst_mode ? n * m_p : -1;
      $display("run start: high=%0d period=%0d burst=%0d pulses=%0d",
               m_h1, m_p, bus.burst_mode, n);
    end
    m_armed  = 1;
    exp_adc  = m_active && ((m_k % m_p) < m_h1);
    exp_busy = m_active;
    hist[2] = hist[1];
    hist[1] = hist[0];
    hist[0] = prev_adc;
    prev_adc = exp_adc;
`ifdef SYSREF_DAC_SKEW_EN
    exp_dac = (dac_skew == 0) ? exp_adc : hist[dac_skew - 1];
`else
    exp_dac = exp_adc;
`endif
  endtask

  task automatic compare_outputs();
    check_val("adc",  int'(bus.user_sysref_adc), int'(exp_adc));
    check_val("dac",  int'(bus.user_sysref_dac), int'(exp_dac));
    check_val("busy", int'(bus.busy),            int'(exp_busy));
    check_val("done", int'(bus.done),            int'(exp_done));
  endtask

  task automatic tick();
    @(posedge master_clock);
    model_step();
    #1;
    compare_outputs();
    bus.start = 1'b0;
    bus.stop  = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wait_idle(input int budget);
    int i;
    i = 0;
    while (m_active && i < budget) begin
      tick();
      i++;
    end
    if (m_active) check_val("idle_timeout", 1, 0);
  endtask

  task automatic do_start(input int hp, input bit bm, input int bc);
    bus.half_period = hp[HP_W-1:0];
    bus.burst_mode  = bm;
    bus.burst_count = bc[BURST_W-1:0];
    bus.start       = 1'b1;
    tick();
  endtask

  task automatic do_reset(input int cycles);
    @(negedge master_clock);
    aresetn = 1'b0;
    #1;
    model_reset();
    compare_outputs();
    for (int i = 0; i < cycles; i++) begin
      @(posedge master_clock);
      #1;
      compare_outputs();
    end
    @(negedge master_clock);
    aresetn = 1'b1;
    $display("reset released");
  endtask

  initial begin
    aresetn         = 1'b0;
    bus.half_period = '0;
    bus.burst_mode  = 1'b0;
    bus.burst_count = '0;
    bus.start       = 1'b0;
    bus.stop        = 1'b0;
`ifdef SYSREF_DAC_SKEW_EN
    dac_skew        = 2'd2;
`endif
    model_reset();
    #1;
    compare_outputs();
    do_reset(2);

    // Start on the first edge after release must be ignored.
    do_start(3, 0, 0);
    check_val("armed_ignore_busy", int'(bus.busy), 0);
    tick();

    // Continuous, half_period=3; parameter changes while busy must not matter.
    do_start(3, 0, 0);
    bus.half_period = 7;
    bus.burst_mode  = 1;
    bus.burst_count = 1;
    ticks(24);
    bus.stop = 1'b1;
    tick();
    wait_idle(40);
    ticks(3);

    // Burst of 3 pulses, half_period=2.
    do_start(2, 1, 3);
    wait_idle(60);
    check_val("burst_done_busy", int'(bus.busy), 0);
    ticks(4);

    // Stop on the second high cycle with half_period=5.
    do_start(5, 0, 0);
    tick();
    bus.stop = 1'b1;
    tick();
    wait_idle(40);
    ticks(12);

    // Simultaneous start and stop in IDLE.
    bus.start = 1'b1;
    bus.stop  = 1'b1;
    tick();
    check_val("startstop_busy", int'(bus.busy), 0);
    ticks(3);

    // Stop during LOW ends on the next cycle.
    do_start(2, 0, 0);
    ticks(4);
    bus.stop = 1'b1;
    tick();
    check_val("low_stop_done", int'(bus.done), 1);
    ticks(3);

    // One-cycle reset mid-HIGH, then a clean restart.
    do_start(5, 0, 0);
    ticks(2);
    do_reset(1);
    tick();
    do_start(1, 1, 2);
    wait_idle(40);
    ticks(2);

    // half_period=0 behaves as 1; burst_count=0 means 2^BURST_W pulses.
    do_start(0, 1, 0);
    wait_idle(1200);
    ticks(2);

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      bus.half_period = HP_W'($urandom_range(0, 5));
      bus.burst_mode  = 1'($urandom_range(0, 1));
      bus.burst_count = BURST_W'($urandom_range(1, 4));
      bus.start       = ($urandom_range(0, 7) == 0);
      bus.stop        = ($urandom_range(0, 15) == 0);
`ifdef SYSREF_DAC_SKEW_EN
      if ($urandom_range(0, 63) == 0) dac_skew = 2'($urandom_range(0, 3));
`endif
      tick();
    end
    bus.stop = 1'b1;
    tick();
    wait_idle(40);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
